// File: rtl/bcd_timer.sv
// Multi-digit BCD up/down timer with tick prescaler, preset load and terminal-count detect.
// count_bcd moves on the tick edge, hex is a registered decode one cycle behind; commands are level-sampled, no backpressure.
module bcd_timer #(
    parameter int TICK_DIV = 50_000_000,
    parameter int DIGITS   = 2,
    parameter int WRAP     = 0
) (
    input  logic                  clk,
    input  logic                  reset_n,
    input  logic                  start,
    input  logic                  pause,
    input  logic                  clear,
    input  logic                  load,
    input  logic [4*DIGITS-1:0]   load_bcd,
    input  logic                  dir,
    output logic [4*DIGITS-1:0]   count_bcd,
    output logic [7*DIGITS-1:0]   hex,
    output logic                  running,
    output logic                  done
);
    localparam int PW = (TICK_DIV > 2) ? $clog2(TICK_DIV) : 1;
    localparam logic [PW-1:0] PS_LAST = PW'(TICK_DIV - 1);

    typedef enum logic [1:0] {S_IDLE, S_RUN, S_PAUSE, S_DONE} state_t;

    state_t                r_state;
    state_t                w_state_nxt;
    logic [PW-1:0]         r_presc;
    logic [PW-1:0]         w_presc_nxt;
    logic [4*DIGITS-1:0]   r_count;
    logic [4*DIGITS-1:0]   w_count_nxt;
    logic [4*DIGITS-1:0]   w_inc;
    logic [4*DIGITS-1:0]   w_dec;
    logic [4*DIGITS-1:0]   w_load_sat;
    logic [7*DIGITS-1:0]   r_hex;
    logic                  r_done;
    logic                  w_done_nxt;
    logic                  w_tick;
    logic                  w_carry;
    logic                  w_borrow;
    logic                  w_term;

    function automatic logic [6:0] f_seg(input logic [3:0] d);
        case (d)
            4'd0:    f_seg = 7'h40;
            4'd1:    f_seg = 7'h79;
            4'd2:    f_seg = 7'h24;
            4'd3:    f_seg = 7'h30;
            4'd4:    f_seg = 7'h19;
            4'd5:    f_seg = 7'h12;
            4'd6:    f_seg = 7'h02;
            4'd7:    f_seg = 7'h78;
            4'd8:    f_seg = 7'h00;
            4'd9:    f_seg = 7'h10;
            default: f_seg = 7'h7F;
        endcase
    endfunction

    // Ripple carry/borrow across digits; a carry or borrow out of the top digit is the terminal count.
    always_comb begin
        w_inc    = r_count;
        w_dec    = r_count;
        w_carry  = 1'b1;
        w_borrow = 1'b1;
        for (int i = 0; i < DIGITS; i++) begin
            if (w_carry) begin
                if (r_count[4*i +: 4] >= 4'd9) begin
                    w_inc[4*i +: 4] = 4'd0;
                end else begin
                    w_inc[4*i +: 4] = r_count[4*i +: 4] + 4'd1;
                    w_carry         = 1'b0;
                end
            end
            if (w_borrow) begin
                if (r_count[4*i +: 4] == 4'd0) begin
                    w_dec[4*i +: 4] = 4'd9;
                end else begin
                    w_dec[4*i +: 4] = r_count[4*i +: 4] - 4'd1;
                    w_borrow        = 1'b0;
                end
            end
        end
    end

    always_comb begin
        w_load_sat = load_bcd;
        for (int i = 0; i < DIGITS; i++) begin
            if (load_bcd[4*i +: 4] > 4'd9) begin
                w_load_sat[4*i +: 4] = 4'd9;
            end
        end
    end

    assign w_tick = (r_state == S_RUN) && (r_presc == PS_LAST);
    assign w_term = dir ? w_carry : w_borrow;

    always_comb begin
        w_state_nxt = r_state;
        w_presc_nxt = r_presc;
        w_count_nxt = r_count;
        w_done_nxt  = 1'b0;
        if (clear) begin
            w_state_nxt = S_IDLE;
            w_presc_nxt = '0;
            w_count_nxt = '0;
        end else if (load) begin
            w_state_nxt = S_IDLE;
            w_presc_nxt = '0;
            w_count_nxt = w_load_sat;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (start && !pause) w_state_nxt = S_RUN;
                end
                S_RUN: begin
                    // A pause on the tick cycle keeps the prescaler at its last value so the tick fires right after resume.
                    if (pause) begin
                        w_state_nxt = S_PAUSE;
                    end else if (w_tick) begin
                        w_presc_nxt = '0;
                        if (w_term) begin
                            w_done_nxt = 1'b1;
                            if (WRAP != 0) begin
                                w_count_nxt = dir ? w_inc : w_dec;
                            end else begin
                                w_state_nxt = S_DONE;
                            end
                        end else begin
                            w_count_nxt = dir ? w_inc : w_dec;
                        end
                    end else begin
                        w_presc_nxt = r_presc + PW'(1);
                    end
                end
                S_PAUSE: begin
                    if (start && !pause) w_state_nxt = S_RUN;
                end
                default: begin
                    w_state_nxt = r_state;
                end
            endcase
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_state <= S_IDLE;
            r_presc <= '0;
            r_count <= '0;
            r_done  <= 1'b0;
            r_hex   <= {DIGITS{7'h40}};
        end else begin
            r_state <= w_state_nxt;
            r_presc <= w_presc_nxt;
            r_count <= w_count_nxt;
            r_done  <= w_done_nxt;
            for (int i = 0; i < DIGITS; i++) begin
                r_hex[7*i +: 7] <= f_seg(r_count[4*i +: 4]);
            end
        end
    end

    assign count_bcd = r_count;
    assign hex       = r_hex;
    assign running   = (r_state == S_RUN);
    assign done      = r_done;

endmodule

// File: tb/tb_bcd_timer.sv
// Bench for bcd_timer: one WRAP=0 and one WRAP=1 instance (DIGITS=2, TICK_DIV=4) on shared stimulus.
module tb_bcd_timer;
    localparam int TD   = 4;
    localparam int MAXV = 99;
    localparam int M_IDLE = 0, M_RUN = 1, M_PAUSE = 2, M_DONE = 3;

    logic        clk = 1'b0;
    logic        reset_n = 1'b0;
    logic        start = 1'b0, pause = 1'b0, clear = 1'b0, load = 1'b0, dir = 1'b1;
    logic [7:0]  load_bcd = 8'h00;
    logic [7:0]  cnt0, cnt1;
    logic [13:0] hex0, hex1;
    logic        run0, run1, dn0, dn1;

    int n_err = 0;
    int n_chk = 0;

    int mc[2], mp[2], ms[2], mh[2];
    bit md[2];

    bcd_timer #(.TICK_DIV(TD), .DIGITS(2), .WRAP(0)) u_dut0 (
        .clk(clk), .reset_n(reset_n), .start(start), .pause(pause), .clear(clear),
        .load(load), .load_bcd(load_bcd), .dir(dir),
        .count_bcd(cnt0), .hex(hex0), .running(run0), .done(dn0));

    bcd_timer #(.TICK_DIV(TD), .DIGITS(2), .WRAP(1)) u_dut1 (
        .clk(clk), .reset_n(reset_n), .start(start), .pause(pause), .clear(clear),
        .load(load), .load_bcd(load_bcd), .dir(dir),
        .count_bcd(cnt1), .hex(hex1), .running(run1), .done(dn1));

    always #5 clk = ~clk;

    function automatic int seg(int d);
        case (d)
            0: return 'h40;  1: return 'h79;  2: return 'h24;  3: return 'h30;
            4: return 'h19;  5: return 'h12;  6: return 'h02;  7: return 'h78;
            8: return 'h00;  9: return 'h10;
            default: return 'h7F;
        endcase
    endfunction

    function automatic int hx(int b);
        return (seg(b / 16) << 7) | seg(b % 16);
    endfunction

    function automatic int sat(int d);
        return (d > 9) ? 9 : d;
    endfunction

    function automatic int to_bcd(int v);
        return (v / 10) * 16 + (v % 10);
    endfunction

    task automatic chk(input string name, input int act, input int exp);
        n_chk++;
        if (act != exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Reference: count held as a plain integer 0..99, ticks every TD running cycles.
    always @(posedge clk) begin
        for (int k = 0; k < 2; k++) begin
            if (!reset_n) begin
                mc[k] = 0; mp[k] = 0; ms[k] = M_IDLE; md[k] = 0; mh[k] = 0;
            end else begin
                mh[k] = mc[k];
                md[k] = 0;
                if (clear) begin
                    mc[k] = 0; mp[k] = 0; ms[k] = M_IDLE;
                end else if (load) begin
                    mc[k] = sat(int'(load_bcd[7:4])) * 10 + sat(int'(load_bcd[3:0]));
                    mp[k] = 0; ms[k] = M_IDLE;
                end else if (ms[k] == M_IDLE || ms[k] == M_PAUSE) begin
                    if (start && !pause) ms[k] = M_RUN;
                end else if (ms[k] == M_RUN) begin
                    if (pause) begin
                        ms[k] = M_PAUSE;
                    end else if (mp[k] == TD - 1) begin
                        mp[k] = 0;
                        if ((dir && mc[k] == MAXV) || (!dir && mc[k] == 0)) begin
                            md[k] = 1;
                            if (k == 1) mc[k] = dir ? (mc[k] + 1) % (MAXV + 1) : (mc[k] + MAXV) % (MAXV + 1);
                            else        ms[k] = M_DONE;
                        end else begin
                            mc[k] = dir ? mc[k] + 1 : mc[k] - 1;
                        end
                    end else begin
                        mp[k] = mp[k] + 1;
                    end
                end
            end
        end
    end

    task automatic cycle();
        @(posedge clk);
        @(negedge clk);
        chk("m0.count", int'(cnt0), to_bcd(mc[0]));
        chk("m0.hex",   int'(hex0), hx(to_bcd(mh[0])));
        chk("m0.run",   int'(run0), (ms[0] == M_RUN) ? 1 : 0);
        chk("m0.done",  int'(dn0),  int'(md[0]));
        chk("m1.count", int'(cnt1), to_bcd(mc[1]));
        chk("m1.hex",   int'(hex1), hx(to_bcd(mh[1])));
        chk("m1.run",   int'(run1), (ms[1] == M_RUN) ? 1 : 0);
        chk("m1.done",  int'(dn1),  int'(md[1]));
    endtask

    task automatic chk_reset_vals(input string tag);
        chk({tag, ".count0"}, int'(cnt0), 0);
        chk({tag, ".hex0"},   int'(hex0), 'h2040);
        chk({tag, ".run0"},   int'(run0), 0);
        chk({tag, ".done0"},  int'(dn0),  0);
        chk({tag, ".count1"}, int'(cnt1), 0);
        chk({tag, ".hex1"},   int'(hex1), 'h2040);
        chk({tag, ".run1"},   int'(run1), 0);
        chk({tag, ".done1"},  int'(dn1),  0);
    endtask

    typedef struct {
        bit w; bit c; bit l; bit p; bit s; bit d;
        int lb; int n;
        int ecnt; int ehex; bit erun; bit edone;
    } vec_t;

    function automatic vec_t mk(bit w, bit c, bit l, bit p, bit s, bit d, int lb, int n,
                                int ecnt, int ehex, bit erun, bit edone);
        vec_t v;
        v.w = w; v.c = c; v.l = l; v.p = p; v.s = s; v.d = d; v.lb = lb; v.n = n;
        v.ecnt = ecnt; v.ehex = ehex; v.erun = erun; v.edone = edone;
        return v;
    endfunction

    initial begin
        vec_t tv[$];
        //             w c l p s d  lb     n   cnt    hex        run done
        tv.push_back(mk(0,0,0,0,1,1, 0,     1,  'h00, hx('h00), 1, 0));
        tv.push_back(mk(0,0,0,0,0,1, 0,     3,  'h00, hx('h00), 1, 0));
        tv.push_back(mk(0,0,0,0,0,1, 0,     1,  'h01, hx('h00), 1, 0));
        tv.push_back(mk(0,0,0,0,0,1, 0,     32, 'h09, hx('h08), 1, 0));
        tv.push_back(mk(0,0,0,0,0,1, 0,     4,  'h10, hx('h09), 1, 0));
        tv.push_back(mk(0,0,0,1,0,1, 0,     1,  'h10, hx('h10), 0, 0));
        tv.push_back(mk(0,0,0,1,0,1, 0,     49, 'h10, hx('h10), 0, 0));
        tv.push_back(mk(0,0,0,0,1,1, 0,     1,  'h10, hx('h10), 1, 0));
        tv.push_back(mk(0,0,0,0,0,1, 0,     3,  'h10, hx('h10), 1, 0));
        tv.push_back(mk(0,0,0,0,0,1, 0,     1,  'h11, hx('h10), 1, 0));
        tv.push_back(mk(0,0,0,0,0,1, 0,     3,  'h11, hx('h11), 1, 0));
        tv.push_back(mk(0,0,0,1,0,1, 0,     1,  'h11, hx('h11), 0, 0));
        tv.push_back(mk(0,0,0,1,0,1, 0,     5,  'h11, hx('h11), 0, 0));
        tv.push_back(mk(0,0,0,0,1,1, 0,     1,  'h11, hx('h11), 1, 0));
        tv.push_back(mk(0,0,0,0,0,1, 0,     1,  'h12, hx('h11), 1, 0));
        tv.push_back(mk(0,0,1,0,0,1, 'h98,  1,  'h98, hx('h12), 0, 0));
        tv.push_back(mk(0,0,0,0,1,1, 0,     1,  'h98, hx('h98), 1, 0));
        tv.push_back(mk(0,0,0,0,0,1, 0,     4,  'h99, hx('h98), 1, 0));
        tv.push_back(mk(0,0,0,0,0,1, 0,     3,  'h99, hx('h99), 1, 0));
        tv.push_back(mk(0,0,0,0,0,1, 0,     1,  'h99, hx('h99), 0, 1));
        tv.push_back(mk(0,0,0,0,0,1, 0,     1,  'h99, hx('h99), 0, 0));
        tv.push_back(mk(0,0,0,0,1,1, 0,     5,  'h99, hx('h99), 0, 0));
        tv.push_back(mk(0,1,0,0,0,1, 0,     1,  'h00, hx('h99), 0, 0));
        tv.push_back(mk(0,0,0,0,0,1, 0,     2,  'h00, hx('h00), 0, 0));
        tv.push_back(mk(0,1,1,0,1,1, 'h55,  1,  'h00, hx('h00), 0, 0));
        tv.push_back(mk(0,0,1,0,0,1, 'hA5,  1,  'h95, hx('h00), 0, 0));
        tv.push_back(mk(0,0,0,0,0,1, 0,     1,  'h95, hx('h95), 0, 0));
        tv.push_back(mk(0,0,0,0,1,1, 0,     1,  'h95, hx('h95), 1, 0));
        tv.push_back(mk(0,0,0,0,0,1, 0,     3,  'h95, hx('h95), 1, 0));
        tv.push_back(mk(0,0,1,0,0,1, 'h42,  1,  'h42, hx('h95), 0, 0));
        tv.push_back(mk(0,0,1,0,0,1, 'h99,  1,  'h99, hx('h42), 0, 0));
        tv.push_back(mk(0,0,0,0,1,1, 0,     1,  'h99, hx('h99), 1, 0));
        tv.push_back(mk(0,0,0,0,0,1, 0,     3,  'h99, hx('h99), 1, 0));
        tv.push_back(mk(0,1,0,0,0,1, 0,     1,  'h00, hx('h99), 0, 0));
        tv.push_back(mk(0,0,0,0,0,1, 0,     1,  'h00, hx('h00), 0, 0));
        tv.push_back(mk(1,0,1,0,0,1, 'h01,  1,  'h01, hx('h00), 0, 0));
        tv.push_back(mk(1,0,0,0,1,0, 0,     1,  'h01, hx('h01), 1, 0));
        tv.push_back(mk(1,0,0,0,0,0, 0,     3,  'h01, hx('h01), 1, 0));
        tv.push_back(mk(1,0,0,0,0,0, 0,     1,  'h00, hx('h01), 1, 0));
        tv.push_back(mk(1,0,0,0,0,0, 0,     4,  'h99, hx('h00), 1, 1));
        tv.push_back(mk(1,0,0,0,0,0, 0,     1,  'h99, hx('h99), 1, 0));
        tv.push_back(mk(1,0,0,0,0,0, 0,     3,  'h98, hx('h99), 1, 0));
        tv.push_back(mk(1,0,0,0,0,0, 0,     2,  'h98, hx('h98), 1, 0));
        tv.push_back(mk(1,0,0,0,0,1, 0,     2,  'h99, hx('h98), 1, 0));

        // Reset held, then idle with no start.
        @(negedge clk);
        chk_reset_vals("rst");
        reset_n = 1'b1;
        repeat (20) cycle();
        chk_reset_vals("idle");

        for (int i = 0; i < tv.size(); i++) begin
            clear = tv[i].c; load = tv[i].l; pause = tv[i].p; start = tv[i].s;
            dir = tv[i].d; load_bcd = 8'(tv[i].lb);
            repeat (tv[i].n) cycle();
            chk($sformatf("v%0d.count", i), tv[i].w ? int'(cnt1) : int'(cnt0), tv[i].ecnt);
            chk($sformatf("v%0d.hex", i),   tv[i].w ? int'(hex1) : int'(hex0), tv[i].ehex);
            chk($sformatf("v%0d.run", i),   tv[i].w ? int'(run1) : int'(run0), int'(tv[i].erun));
            chk($sformatf("v%0d.done", i),  tv[i].w ? int'(dn1)  : int'(dn0),  int'(tv[i].edone));
        end

        // Asynchronous reset in the middle of a prescaler period.
        clear = 0; load = 0; pause = 0; start = 0; dir = 1;
        repeat (2) cycle();
        #2 reset_n = 1'b0;
        #1 chk_reset_vals("arst");
        @(negedge clk);
        reset_n = 1'b1;
        cycle();

        for (int i = 0; i < 3000; i++) begin
            clear = ($urandom % 100) == 0;
            load  = ($urandom % 40) == 0;
            pause = ($urandom % 12) == 0;
            start = ($urandom % 4) == 0;
            if (($urandom % 30) == 0) dir = ~dir;
            case ($urandom % 5)
                0:       load_bcd = 8'h99;
                1:       load_bcd = 8'h98;
                2:       load_bcd = 8'h00;
                3:       load_bcd = 8'h01;
                default: load_bcd = 8'($urandom % 256);
            endcase
            cycle();
        end

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

endmodule

// File: doc/bcd_timer.md
# bcd_timer

Parametrised multi-digit BCD stopwatch/countdown timer with an internal tick prescaler, up/down counting, preset load, terminal-count detection and registered active-low seven-segment outputs per digit. It is the general-purpose timer for board-level demos in the NPC tree. It replaces fixed two-digit, free-running counters with a controlled run/pause/done state machine.

## Interface
- TICK_DIV, 50_000_000: clk cycles per count tick (≥2).
- DIGITS, 2: number of BCD digits (1..8); count range 0..10^DIGITS−1.
- WRAP, 0: 1 = wrap at terminal count and keep running; 0 = stop in DONE.
- clk  in  1  system clock, all state on rising edge.
- reset_n  in  1  asynchronous, active-low reset.
- start  in  1  level-sampled each cycle; begin or resume counting.
- pause  in  1  hold count, freeze prescaler.
- clear  in  1  synchronous: count and prescaler to 0, go IDLE.
- load  in  1  synchronous: count ← load_bcd, prescaler to 0, go IDLE.
- load_bcd  in  4*DIGITS  preset value, digit i at [4i+3:4i].
- dir  in  1  1 = count up, 0 = count down; sampled at each tick.
- count_bcd  out  4*DIGITS  current count, digit i at [4i+3:4i].
- hex  out  7*DIGITS  segments digit i at [7i+6:7i] = {g,f,e,d,c,b,a}, active-low.
- running  out  1  high in RUN.
- done  out  1  one-cycle pulse on terminal count.

## Operation
- States: IDLE, RUN, PAUSE, DONE. Reset → IDLE, count 0, prescaler 0.
- Command priority per cycle: clear > load > pause > start.
- IDLE: start → RUN. PAUSE: start and not pause → RUN. RUN: pause → PAUSE. DONE: start → RUN only after clear/load. start alone in DONE is ignored.
- Prescaler: counts 0..TICK_DIV−1 only in RUN. It holds in PAUSE. tick = RUN && prescaler==TICK_DIV−1, and the prescaler then returns to 0.
- On tick, dir=1: BCD increment with per-digit carry (9→0, carry up). dir=0: BCD decrement with borrow (0→9).
- Terminal: up at all-9s, or down at all-0s, on a tick.
  - WRAP=1: count wraps (to 0 up, to all-9s down), done pulses, stay RUN.
  - WRAP=0: count holds, done pulses, go DONE.
- load_bcd digits >9 are saturated to 9 on load.
- hex digit encode (hex value of 7-bit pattern): 0:40 1:79 2:24 3:30 4:19 5:12 6:02 7:78 8:00 9:10. Any other value drives 7F (blank).
- running = (state==RUN), decoded from the registered state.

## Timing
- Reset values: count_bcd 0, hex all digits 40, running 0, done 0. Reset takes effect immediately, mid-count included.
- start asserted at edge N moves to RUN at N. The first tick comes TICK_DIV cycles later, and count_bcd changes at edge N+TICK_DIV.
- count_bcd updates on the tick edge. hex lags count_bcd by exactly 1 cycle (registered decode).
- done is high for the single cycle following the terminal tick edge.
- clear/load take effect at the sampling edge, even coincident with a tick. The tick is discarded and done does not pulse.
- pause coincident with a tick: pause wins, no count change, and the prescaler holds at TICK_DIV−1. The tick fires on the first cycle after resume.
- Changing dir mid-run has no effect on the prescaler and applies at the next tick.

## Test plan
- Reset/idle, DIGITS=2, TICK_DIV=4: release reset_n, no start for 20 cycles → count_bcd 00, hex 40_40, running 0, done 0.
- Up count: start 1 cycle → count 01 at +4 cycles, 09→10 carry at +40, hex 79 on digit1 and 40 on digit0 one cycle after.
- WRAP=0 up: load 98, start → 99 after 4 cycles, single done pulse after 8 cycles, state DONE, count stays 99. start alone keeps DONE. clear → 00 IDLE.
- WRAP=1 down: load 01, dir=0, start → 00, then 99 with one done pulse, running stays 1, next tick 98.
- Pause: run 10 ticks, assert pause for 50 cycles → count frozen at 10. Release with start → 11 exactly 4 cycles after resume (with pause at tick: 1 cycle).
- Priority/async: clear+load+start same cycle → 00 IDLE. load A5 → 95. Drop reset_n mid-tick → outputs to reset values immediately.
